// File: rtl/cache_array.sv
// ---------------------------------------------------------------------------
// cache_array
//
// Direct-mapped cache of LINES lines. Each line holds a valid bit, a tag and
// one data word. It supports read lookups, write-on-hit, forced allocation
// and a multi-cycle flush sweep that invalidates every line. All responses
// are registered and appear one cycle after the request is sampled.
//
// Address split: index = in_addr[IDX_W-1:0], tag = in_addr[ADDR_W-1:IDX_W].
//
// Optional feature macro: CACHE_STATS_EN
//   When defined, adds saturating read hit/miss counters (hit_count,
//   miss_count). These are cleared only by reset.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   in_addr      in   request address
//   in_val       in   write data
//   read         in   read request
//   write        in   write request (ignored when read is also high)
//   force_write  in   allocate the line on write even on a miss
//   flush        in   start the invalidate sweep
//   resp_valid   out  one-cycle pulse marking an accepted access
//   hit          out  lookup result of the last accepted access
//   out_val      out  read data of the last accepted read (0 on miss)
//   busy         out  flush sweep in progress, accesses ignored
//   hit_count    out  (CACHE_STATS_EN) accepted reads that hit
//   miss_count   out  (CACHE_STATS_EN) accepted reads that missed
// ---------------------------------------------------------------------------
module cache_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LINES  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_val,
    input  logic              read,
    input  logic              write,
    input  logic              force_write,
    input  logic              flush,
    output logic              resp_valid,
    output logic              hit,
    output logic [DATA_W-1:0] out_val,
    output logic              busy
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    // Reject configurations the index arithmetic cannot represent.
    if (LINES < 2 || (1 << IDX_W) != LINES || STAT_W < 1) begin : gBadParams
        $error("cache_array: LINES must be a power of two >= 2 and STAT_W >= 1");
    end

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [IDX_W-1:0]  sweep_q;
    logic [IDX_W-1:0]  sweep_d;
    logic              resp_q;
    logic              hit_q;
    logic [DATA_W-1:0] outVal_q;
    logic              busy_q;

    logic [TAG_W-1:0]  tagMem_q  [LINES];
    logic [DATA_W-1:0] dataMem_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hitC;
    logic              readAccept;
    logic              writeAccept;
    logic              allocate;

    assign idx  = in_addr[IDX_W-1:0];
    assign tag  = in_addr[ADDR_W-1:IDX_W];
    assign hitC = valid_q[idx] && (tagMem_q[idx] == tag);

    // Flush wins over read, read wins over write; nothing is accepted mid-sweep.
    assign readAccept  = (state_q == IDLE) && !flush && read;
    assign writeAccept = (state_q == IDLE) && !flush && !read && write;
    assign allocate    = writeAccept && (hitC || force_write);

    // The sweep index wraps naturally at LINES.
    assign sweep_d = sweep_q + 1'b1;

    assign resp_valid = resp_q;
    assign hit        = hit_q;
    assign out_val    = outVal_q;
    assign busy       = busy_q;

    // Control FSM: owns valid bits, the sweep index and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            sweep_q  <= '0;
            resp_q   <= 1'b0;
            hit_q    <= 1'b0;
            outVal_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (flush) begin
                        state_q <= FLUSH;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (readAccept) begin
                        resp_q   <= 1'b1;
                        hit_q    <= hitC;
                        outVal_q <= hitC ? dataMem_q[idx] : '0;
                    end else if (writeAccept) begin
                        resp_q <= 1'b1;
                        hit_q  <= hitC;
                        if (allocate) begin
                            valid_q[idx] <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    resp_q           <= 1'b0;
                    valid_q[sweep_q] <= 1'b0;
                    sweep_q          <= sweep_d;
                    if (sweep_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits alone define contents.
    always_ff @(posedge clock) begin
        if (allocate) begin
            tagMem_q[idx]  <= tag;
            dataMem_q[idx] <= in_val;
        end
    end

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hitCount_q;
    logic [STAT_W-1:0] missCount_q;

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;

    // Saturating read statistics; a flush leaves them untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else if (readAccept) begin
            if (hitC) begin
                if (hitCount_q != '1) begin
                    hitCount_q <= hitCount_q + 1'b1;
                end
            end else begin
                if (missCount_q != '1) begin
                    missCount_q <= missCount_q + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_array.sv
module tb_cache_array;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int LINES  = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] inAddr;
   logic [DATA_W-1:0] inVal;
   logic              rdReq;
   logic              wrReq;
   logic              forceWr;
   logic              flushReq;
   logic              respValid;
   logic              hitOut;
   logic [DATA_W-1:0] outVal;
   logic              busyOut;

   int checks   = 0;
   int failures = 0;

`ifdef CACHE_STATS_EN
   logic [15:0] hitCount;
   logic [15:0] missCount;
   logic [1:0]  hitCountSmall;
   logic [1:0]  missCountSmall;
`endif

   cache_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .STAT_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_addr     (inAddr),
      .in_val      (inVal),
      .read        (rdReq),
      .write       (wrReq),
      .force_write (forceWr),
      .flush       (flushReq),
      .resp_valid  (respValid),
      .hit         (hitOut),
      .out_val     (outVal),
      .busy        (busyOut)
`ifdef CACHE_STATS_EN
      ,
      .hit_count   (hitCount),
      .miss_count  (missCount)
`endif
   );

`ifdef CACHE_STATS_EN
   logic              respValid2;
   logic              hitOut2;
   logic [DATA_W-1:0] outVal2;
   logic              busyOut2;

   // Narrow-counter copy sharing the same stimulus, to observe saturation.
   cache_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .STAT_W(2)) dutSmall (
      .clock       (clock),
      .reset       (reset),
      .in_addr     (inAddr),
      .in_val      (inVal),
      .read        (rdReq),
      .write       (wrReq),
      .force_write (forceWr),
      .flush       (flushReq),
      .resp_valid  (respValid2),
      .hit         (hitOut2),
      .out_val     (outVal2),
      .busy        (busyOut2),
      .hit_count   (hitCountSmall),
      .miss_count  (missCountSmall)
   );
`endif

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Reference model: each line remembers the full address it was filled
   // from, so a hit is simply "valid and same address".
   bit                mValid [LINES];
   logic [ADDR_W-1:0] mAddr  [LINES];
   logic [DATA_W-1:0] mData  [LINES];
   bit                mResp;
   bit                mHit;
   logic [DATA_W-1:0] mOut;
   int                mBusyLeft;
   int                mHits;
   int                mMisses;
   int                mHitsSmall;
   int                mMissesSmall;

   task automatic modelReset();
      for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
      mResp        = 1'b0;
      mHit         = 1'b0;
      mOut         = '0;
      mBusyLeft    = 0;
      mHits        = 0;
      mMisses      = 0;
      mHitsSmall   = 0;
      mMissesSmall = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelEdge();
      int line;
      bit h;
      line = int'(inAddr) % LINES;
      h    = mValid[line] && (mAddr[line] == inAddr);
      if (mBusyLeft > 0) begin
         mValid[LINES - mBusyLeft] = 1'b0;
         mBusyLeft--;
         mResp = 1'b0;
      end else if (flushReq) begin
         mBusyLeft = LINES;
         mResp     = 1'b0;
      end else if (rdReq) begin
         mResp = 1'b1;
         mHit  = h;
         mOut  = h ? mData[line] : '0;
         if (h) begin
            if (mHits < 65535) mHits++;
            if (mHitsSmall < 3) mHitsSmall++;
         end else begin
            if (mMisses < 65535) mMisses++;
            if (mMissesSmall < 3) mMissesSmall++;
         end
      end else if (wrReq) begin
         mResp = 1'b1;
         mHit  = h;
         if (h || forceWr) begin
            mValid[line] = 1'b1;
            mAddr[line]  = inAddr;
            mData[line]  = inVal;
         end
      end else begin
         mResp = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".resp_valid"}, 32'(respValid), 32'(mResp));
      checkOutput({tag, ".hit"},        32'(hitOut),    32'(mHit));
      checkOutput({tag, ".out_val"},    outVal,         mOut);
      checkOutput({tag, ".busy"},       32'(busyOut),   32'(mBusyLeft > 0));
`ifdef CACHE_STATS_EN
      checkOutput({tag, ".hit_count"},  32'(hitCount),       32'(mHits));
      checkOutput({tag, ".miss_count"}, 32'(missCount),      32'(mMisses));
      checkOutput({tag, ".hit_sat"},    32'(hitCountSmall),  32'(mHitsSmall));
      checkOutput({tag, ".miss_sat"},   32'(missCountSmall), 32'(mMissesSmall));
`endif
   endtask

   // Drive one cycle of inputs, clock it in, then compare against the model.
   task automatic applyStimulus(input string tag, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] val, input bit rd, input bit wr,
                                input bit fw, input bit fl);
      inAddr   = addr;
      inVal    = val;
      rdReq    = rd;
      wrReq    = wr;
      forceWr  = fw;
      flushReq = fl;
      @(posedge clock);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   initial begin
      int busyCycles;
      reset    = 1'b1;
      inAddr   = '0;
      inVal    = '0;
      rdReq    = 1'b0;
      wrReq    = 1'b0;
      forceWr  = 1'b0;
      flushReq = 1'b0;
      for (int i = 0; i < LINES; i++) begin
         mAddr[i] = '0;
         mData[i] = '0;
      end
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checkAll("reset");
      @(negedge clock);
      reset = 1'b0;

      // Cold read misses with zero data.
      applyStimulus("t1_read05", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t1_hit", 32'(hitOut), 32'd0);
      checkOutput("t1_resp", 32'(respValid), 32'd1);

      // Forced allocate then hit; aliasing address misses.
      applyStimulus("t2_write05", 8'h05, 32'hDEADBEEF, 0, 1, 1, 0);
      applyStimulus("t2_read05", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t2_out", outVal, 32'hDEADBEEF);
      checkOutput("t2_hit", 32'(hitOut), 32'd1);
      applyStimulus("t2_read09", 8'h09, 32'h0, 1, 0, 0, 0);
      checkOutput("t2_alias_hit", 32'(hitOut), 32'd0);
      checkOutput("t2_alias_out", outVal, 32'd0);

      // Unforced write miss leaves line alone; forced write evicts.
      applyStimulus("t3_write09", 8'h09, 32'h1, 0, 1, 0, 0);
      checkOutput("t3_wr_hit", 32'(hitOut), 32'd0);
      applyStimulus("t3_read05", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t3_keep", outVal, 32'hDEADBEEF);
      applyStimulus("t3_evict09", 8'h09, 32'h1, 0, 1, 1, 0);
      applyStimulus("t3_read05b", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t3_evicted", 32'(hitOut), 32'd0);

      // Fill every line, flush, and measure the busy window.
      for (int i = 0; i < LINES; i++)
         applyStimulus("t4_fill", 8'(8'h10 + i), 32'(32'hA0 + i), 0, 1, 1, 0);
      applyStimulus("t4_flush", 8'h00, 32'h0, 0, 0, 0, 1);
      busyCycles = 0;
      for (int k = 0; k < 3 * LINES && busyOut; k++) begin
         busyCycles++;
         applyStimulus("t4_busy_read", 8'(8'h10 + (k % LINES)), 32'h0, 1, 0, 0, 0);
         checkOutput("t4_busy_resp", 32'(respValid), 32'd0);
      end
      checkOutput("t4_busy_cycles", 32'(busyCycles), 32'(LINES));
      for (int i = 0; i < LINES; i++) begin
         applyStimulus("t4_after", 8'(8'h10 + i), 32'h0, 1, 0, 0, 0);
         checkOutput("t4_after_hit", 32'(hitOut), 32'd0);
      end

      // Simultaneous read and write: read wins, data unchanged.
      applyStimulus("t5_fill05", 8'h05, 32'h77, 0, 1, 1, 0);
      applyStimulus("t5_rdwr05", 8'h05, 32'h2, 1, 1, 0, 0);
      applyStimulus("t5_read05", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t5_unchanged", outVal, 32'h77);

      // Reset in the second flush cycle aborts the sweep at once.
      applyStimulus("t5_flush", 8'h00, 32'h0, 0, 0, 0, 1);
      applyStimulus("t5_flush_c1", 8'h00, 32'h0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("t5_rst_busy", 32'(busyOut), 32'd0);
      checkAll("t5_rst");
      @(negedge clock);
      reset = 1'b0;
      applyStimulus("t5_post_read05", 8'h05, 32'h0, 1, 0, 0, 0);
      checkOutput("t5_post_hit", 32'(hitOut), 32'd0);

      // Random traffic over a small address window to create hits and aliasing.
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand", 8'($urandom_range(0, 15)), $urandom,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                       $urandom_range(0, 1) == 0, $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
